// File: rtl/fp_add_operand_aligner.sv
// Pre-alignment stage for the FP adder: orders two singles by magnitude and
// right-shifts the smaller significand STEP bits per cycle, keeping G/R/S.
module fp_add_operand_aligner #(
  parameter int STEP        = 1,
  parameter int FLUSH_LIMIT = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_exp,
  output logic        out_sign_big,
  output logic        out_sign_small,
  output logic [26:0] out_man_big,
  output logic [26:0] out_man_small,
  output logic        out_swapped,
  output logic        out_special
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  count;

  logic [7:0]  exp_a, exp_b, exp_big, exp_small, diff;
  logic [23:0] sig_a, sig_b, sig_big, sig_small;
  logic        a_big, special, flush;

  logic [7:0]  k;
  logic [26:0] mask, shifted, shift_val;
  logic        lost;

  // Denormals behave as exponent 1 with no hidden bit.
  assign exp_a = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
  assign exp_b = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
  assign sig_a = {a[30:23] != 8'd0, a[22:0]};
  assign sig_b = {b[30:23] != 8'd0, b[22:0]};

  // Full ties resolve to A so out_swapped stays 0.
  assign a_big     = (exp_a > exp_b) || ((exp_a == exp_b) && (sig_a >= sig_b));
  assign exp_big   = a_big ? exp_a : exp_b;
  assign exp_small = a_big ? exp_b : exp_a;
  assign sig_big   = a_big ? sig_a : sig_b;
  assign sig_small = a_big ? sig_b : sig_a;
  assign diff      = exp_big - exp_small;
  assign special   = (a[30:23] == 8'hff) || (b[30:23] == 8'hff);
  assign flush     = !special && (diff >= 8'(FLUSH_LIMIT));

  assign k         = (count < 8'(STEP)) ? count : 8'(STEP);
  assign mask      = (27'd1 << k) - 27'd1;
  assign lost      = |(out_man_small & mask);
  assign shifted   = out_man_small >> k;
  assign shift_val = {shifted[26:1], shifted[0] | lost};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid)
               state_nxt = (special || diff == 8'd0 || flush) ? DONE : SHIFT;
      SHIFT: if (count == k) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= 8'd0;
      out_exp        <= 8'd0;
      out_sign_big   <= 1'b0;
      out_sign_small <= 1'b0;
      out_man_big    <= 27'd0;
      out_man_small  <= 27'd0;
      out_swapped    <= 1'b0;
      out_special    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          out_exp        <= exp_big;
          out_sign_big   <= a_big ? a[31] : b[31];
          out_sign_small <= a_big ? b[31] : a[31];
          out_man_big    <= {sig_big, 3'b000};
          out_man_small  <= flush ? {26'd0, |sig_small} : {sig_small, 3'b000};
          out_swapped    <= !a_big;
          out_special    <= special;
          count          <= diff;
        end
        SHIFT: begin
          out_man_small <= shift_val;
          count         <= count - k;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_operand_aligner.sv
// Bench for fp_add_operand_aligner: STEP=1 and STEP=4 instances share stimulus,
// checked against an arithmetic alignment model and directed plan values.
module tb_fp_add_operand_aligner;

  typedef struct packed {
    logic [7:0]  ex;
    logic        sb;
    logic        ss;
    logic [26:0] mb;
    logic [26:0] ms;
    logic        sw;
    logic        sp;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;

  logic        rdy1, rdy4, v1, v4;
  logic [7:0]  e1, e4;
  logic        sb1, sb4, ss1, ss4, sw1, sw4, sp1, sp4;
  logic [26:0] mb1, mb4, ms1, ms4;
  res_t        cur1, cur4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_add_operand_aligner #(.STEP(1), .FLUSH_LIMIT(27)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .a(a), .b(b),
    .out_valid(v1), .out_ready(out_ready), .out_exp(e1), .out_sign_big(sb1),
    .out_sign_small(ss1), .out_man_big(mb1), .out_man_small(ms1),
    .out_swapped(sw1), .out_special(sp1));

  fp_add_operand_aligner #(.STEP(4), .FLUSH_LIMIT(27)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy4), .a(a), .b(b),
    .out_valid(v4), .out_ready(out_ready), .out_exp(e4), .out_sign_big(sb4),
    .out_sign_small(ss4), .out_man_big(mb4), .out_man_small(ms4),
    .out_swapped(sw4), .out_special(sp4));

  assign cur1 = {e1, sb1, ss1, mb1, ms1, sw1, sp1};
  assign cur4 = {e4, sb4, ss4, mb4, ms4, sw4, sp4};

  // Reference: order by (effective exponent, significand) as one integer key,
  // then align with a single full-width shift that folds lost bits into bit 0.
  function automatic void model(input logic [31:0] pa, input logic [31:0] pb,
                                input int step, output res_t r, output int lat);
    int ea, eb, eg, es, d;
    logic [26:0] ma, mb, mg, msm, mo;
    longint ka, kb;
    logic abig, spc;
    ea = (pa[30:23] == 8'd0) ? 1 : int'(pa[30:23]);
    eb = (pb[30:23] == 8'd0) ? 1 : int'(pb[30:23]);
    ma = {pa[30:23] != 8'd0, pa[22:0], 3'b000};
    mb = {pb[30:23] != 8'd0, pb[22:0], 3'b000};
    ka = longint'(ea) * 134217728 + longint'(ma);
    kb = longint'(eb) * 134217728 + longint'(mb);
    abig = (ka >= kb);
    eg  = abig ? ea : eb;
    es  = abig ? eb : ea;
    mg  = abig ? ma : mb;
    msm = abig ? mb : ma;
    d   = eg - es;
    spc = (pa[30:23] == 8'hff) || (pb[30:23] == 8'hff);
    if (spc || d == 0) begin
      mo = msm; lat = 1;
    end else if (d >= 27) begin
      mo = {26'd0, msm != 27'd0}; lat = 1;
    end else begin
      mo = msm >> d;
      if ((msm % (1 << d)) != 0) mo[0] = 1'b1;
      lat = 1 + (d + step - 1) / step;
    end
    r.ex = eg[7:0];
    r.sb = abig ? pa[31] : pb[31];
    r.ss = abig ? pb[31] : pa[31];
    r.mb = mg;
    r.ms = mo;
    r.sw = !abig;
    r.sp = spc;
  endfunction

  // Presents one pair, records first-valid cycle (0 = timed out) and outputs.
  task automatic do_pair(input logic [31:0] pa, input logic [31:0] pb, input bit rel,
                         output res_t g1, output res_t g4, output int l1, output int l4,
                         output bit acc);
    g1 = '0; g4 = '0; l1 = 0; l4 = 0;
    @(negedge clk);
    a = pa; b = pb; in_valid = 1'b1; out_ready = 1'b0;
    acc = rdy1 && rdy4;
    for (int c = 1; c <= 64 && (l1 == 0 || l4 == 0); c++) begin
      @(negedge clk);
      if (l1 == 0 && v1) begin l1 = c; g1 = cur1; end
      if (l4 == 0 && v4) begin l4 = c; g4 = cur4; end
      in_valid = 1'b0;
    end
    if (rel) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (v1 !== 1'b0 || v4 !== 1'b0 || rdy1 !== 1'b1 || rdy4 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hs got v=%b%b rdy=%b%b want v=00 rdy=11", v1, v4, rdy1, rdy4);
    end
    n_cmp++;
    if (cur1 !== '0 || cur4 !== '0) begin
      n_bad++;
      $display("FAIL reset_out got %h / %h want 0", cur1, cur4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (v1 !== 1'b0 || rdy1 !== 1'b1 || v4 !== 1'b0 || rdy4 !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset got v=%b%b rdy=%b%b want v=00 rdy=11", v1, v4, rdy1, rdy4);
    end
  endtask

  task automatic test_directed;
    logic [31:0] da [4];
    logic [31:0] db [4];
    res_t        de [4];
    int          dl1 [4];
    int          dl4 [4];
    res_t g1, g4;
    int l1, l4;
    bit acc;
    da[0] = 32'h40400000; db[0] = 32'h40A00000;
    de[0] = '{ex:8'd129, sb:1'b0, ss:1'b0, mb:27'h5000000, ms:27'h3000000, sw:1'b1, sp:1'b0};
    dl1[0] = 2; dl4[0] = 2;
    da[1] = 32'h40A00000; db[1] = 32'h40A00000;
    de[1] = '{ex:8'd129, sb:1'b0, ss:1'b0, mb:27'h5000000, ms:27'h5000000, sw:1'b0, sp:1'b0};
    dl1[1] = 1; dl4[1] = 1;
    da[2] = 32'h3F800001; db[2] = 32'h41800000;
    de[2] = '{ex:8'd131, sb:1'b0, ss:1'b0, mb:27'h4000000, ms:27'h0400001, sw:1'b1, sp:1'b0};
    dl1[2] = 5; dl4[2] = 2;
    da[3] = 32'h3F800000; db[3] = 32'h4E800000;
    de[3] = '{ex:8'd157, sb:1'b0, ss:1'b0, mb:27'h4000000, ms:27'h0000001, sw:1'b1, sp:1'b0};
    dl1[3] = 1; dl4[3] = 1;
    for (int i = 0; i < 4; i++) begin
      do_pair(da[i], db[i], 1'b1, g1, g4, l1, l4, acc);
      n_cmp++;
      if (!acc) begin n_bad++; $display("FAIL dir%0d_accept in_ready=%b%b want 11", i, rdy1, rdy4); end
      n_cmp++;
      if (g1 !== de[i]) begin n_bad++; $display("FAIL dir%0d_s1 got %h want %h", i, g1, de[i]); end
      n_cmp++;
      if (g4 !== de[i]) begin n_bad++; $display("FAIL dir%0d_s4 got %h want %h", i, g4, de[i]); end
      n_cmp++;
      if (l1 !== dl1[i] || l4 !== dl4[i]) begin
        n_bad++;
        $display("FAIL dir%0d_lat got %0d/%0d want %0d/%0d", i, l1, l4, dl1[i], dl4[i]);
      end
    end
  endtask

  task automatic test_special_hold;
    res_t g1, g4, want;
    int l1, l4;
    bit acc;
    want = '{ex:8'd255, sb:1'b0, ss:1'b0, mb:27'h4000000, ms:27'h4000000, sw:1'b0, sp:1'b1};
    do_pair(32'h7F800000, 32'h3F800000, 1'b0, g1, g4, l1, l4, acc);
    n_cmp++;
    if (g1 !== want || g4 !== want || l1 !== 1 || l4 !== 1) begin
      n_bad++;
      $display("FAIL special got %h/%h lat %0d/%0d want %h lat 1/1", g1, g4, l1, l4, want);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (cur1 !== want || cur4 !== want || v1 !== 1'b1 || v4 !== 1'b1 ||
          rdy1 !== 1'b0 || rdy4 !== 1'b0) begin
        n_bad++;
        $display("FAIL hold%0d got %h/%h v=%b%b rdy=%b%b want %h v=11 rdy=00",
                 i, cur1, cur4, v1, v4, rdy1, rdy4, want);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy4 !== 1'b1 || v1 !== 1'b0 || v4 !== 1'b0) begin
      n_bad++;
      $display("FAIL release got rdy=%b%b v=%b%b want rdy=11 v=00", rdy1, rdy4, v1, v4);
    end
  endtask

  task automatic test_reset_mid_shift;
    res_t g1, g4, w1, w4;
    int l1, l4, x1, x4;
    bit acc;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h49800000; in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    n_cmp++;
    if (v1 !== 1'b0 || v4 !== 1'b0 || rdy1 !== 1'b0 || rdy4 !== 1'b0) begin
      n_bad++;
      $display("FAIL midshift_busy got v=%b%b rdy=%b%b want v=00 rdy=00", v1, v4, rdy1, rdy4);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (v1 !== 1'b0 || v4 !== 1'b0 || rdy1 !== 1'b1 || rdy4 !== 1'b1 ||
        cur1 !== '0 || cur4 !== '0) begin
      n_bad++;
      $display("FAIL async_reset got v=%b%b rdy=%b%b out %h/%h want v=00 rdy=11 out 0",
               v1, v4, rdy1, rdy4, cur1, cur4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_pair(32'h40400000, 32'h40A00000, 1'b1, g1, g4, l1, l4, acc);
    model(32'h40400000, 32'h40A00000, 1, w1, x1);
    model(32'h40400000, 32'h40A00000, 4, w4, x4);
    n_cmp++;
    if (!acc || g1 !== w1 || g4 !== w4 || l1 !== x1 || l4 !== x4) begin
      n_bad++;
      $display("FAIL after_reset acc=%b got %h/%h lat %0d/%0d want %h/%h lat %0d/%0d",
               acc, g1, g4, l1, l4, w1, w4, x1, x4);
    end
  endtask

  // Back-to-back random pairs: each new pair is offered the cycle after release.
  task automatic test_random;
    res_t g1, g4, w1, w4;
    int l1, l4, x1, x4, ea, eb, t, r;
    logic [31:0] pa, pb;
    bit acc;
    for (int i = 0; i < 150; i++) begin
      ea = $urandom_range(0, 254);
      r  = $urandom_range(0, 9);
      if (r == 0) eb = 255;
      else if (r == 1) eb = 0;
      else if (r == 2) eb = ea;
      else begin
        t = ea + int'($urandom_range(0, 64)) - 32;
        eb = (t < 0) ? 0 : (t > 254) ? 254 : t;
      end
      pa = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      pb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) pb[22:0] = pa[22:0];
      if ($urandom_range(0, 1) == 1) begin
        t = 0; {pa, pb} = {pb, pa};
      end
      model(pa, pb, 1, w1, x1);
      model(pa, pb, 4, w4, x4);
      do_pair(pa, pb, 1'b1, g1, g4, l1, l4, acc);
      n_cmp++;
      if (!acc || g1 !== w1 || l1 !== x1) begin
        n_bad++;
        $display("FAIL rnd%0d_s1 a=%h b=%h acc=%b got %h lat %0d want %h lat %0d",
                 i, pa, pb, acc, g1, l1, w1, x1);
      end
      n_cmp++;
      if (g4 !== w4 || l4 !== x4) begin
        n_bad++;
        $display("FAIL rnd%0d_s4 a=%h b=%h got %h lat %0d want %h lat %0d",
                 i, pa, pb, g4, l4, w4, x4);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_special_hold;
    test_reset_mid_shift;
    test_random;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
